// File: rtl/decode_ctrl_pkg.sv
// Decode-stage shared types: opcodes, immediate selects,
// the control bundle and the instruction decode function.
package decode_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic alu_src;
        logic is_muldiv;
        logic alu_sub_sra;
    } ctrl_t;

    typedef struct packed {
        ctrl_t      ctrl;
        logic [2:0] imm_src;
        logic       illegal;
    } dec_t;

    function automatic dec_t decode(
        input logic [31:0] instr,
        input logic        fence_nop
    );
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       wr;
        d  = '0;
        f3 = instr[14:12];
        f7 = instr[31:25];
        wr = 1'b0;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
                d.imm_src = IMM_U;
                wr        = 1'b1;
            end
            OPC_JAL: begin
                d.imm_src   = IMM_J;
                d.ctrl.jump = 1'b1;
                wr          = 1'b1;
            end
            OPC_JALR: begin
                d.ctrl.jump = 1'b1;
                wr          = 1'b1;
                d.illegal   = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                d.imm_src     = IMM_B;
                d.ctrl.branch = 1'b1;
                d.illegal     = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                d.ctrl.mem_read = 1'b1;
                wr              = 1'b1;
                d.illegal       = (f3 == 3'b011)
                                | (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                d.imm_src        = IMM_S;
                d.ctrl.mem_write = 1'b1;
                d.illegal        = (f3 > 3'b010);
            end
            OPC_OPIMM: begin
                d.ctrl.alu_src = 1'b1;
                wr             = 1'b1;
                if (f3 == 3'b001) begin
                    d.illegal = (f7 != F7_BASE);
                end else if (f3 == 3'b101) begin
                    d.illegal = (f7 != F7_BASE)
                              & (f7 != F7_ALT);
                    d.ctrl.alu_sub_sra = (f7 == F7_ALT);
                end
            end
            OPC_OP: begin
                wr = 1'b1;
                if (f7 == F7_ALT) begin
                    d.ctrl.alu_sub_sra = 1'b1;
                    d.illegal = (f3 != 3'b000)
                              & (f3 != 3'b101);
                end else if (f7 == F7_MULDIV) begin
                    d.ctrl.is_muldiv = 1'b1;
                end else begin
                    d.illegal = (f7 != F7_BASE);
                end
            end
            OPC_FENCE: d.illegal = !fence_nop;
            default:   d.illegal = 1'b1;
        endcase
        d.ctrl.reg_write = wr & (instr[11:7] != 5'd0);
        if (d.illegal) begin
            d.ctrl    = '0;
            d.imm_src = IMM_I;
        end
        return d;
    endfunction

endpackage

// File: rtl/decode_ctrl_if.sv
// Fetch-to-decode handshake: instruction word and PC
// offered under valid, consumed when decode raises ready.
interface decode_ctrl_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;

    modport master (
        output if_valid, if_instr, if_pc,
        input  id_ready
    );

    modport slave (
        input  if_valid, if_instr, if_pc,
        output id_ready
    );
endinterface

// File: rtl/decode_ctrl_imm_extend.sv
// Shared immediate extender: builds the sign-extended
// immediate for the selected instruction format.
module decode_ctrl_imm_extend
    import decode_ctrl_pkg::*;
(
    input  logic [31:7] i_instr,
    input  logic [2:0]  i_imm_src,
    output logic [31:0] o_imm
);
    logic w_s;
    assign w_s = i_instr[31];

    // Format select; unused encodings yield zero.
    always_comb begin
        o_imm = '0;
        case (i_imm_src)
            IMM_I: o_imm = {{20{w_s}}, i_instr[31:20]};
            IMM_S: o_imm = {{20{w_s}}, i_instr[31:25],
                            i_instr[11:7]};
            IMM_B: o_imm = {{20{w_s}}, i_instr[7],
                            i_instr[30:25],
                            i_instr[11:8], 1'b0};
            IMM_U: o_imm = {i_instr[31:12], 12'd0};
            IMM_J: o_imm = {{12{w_s}}, i_instr[19:12],
                            i_instr[20], i_instr[30:21],
                            1'b0};
            default: o_imm = '0;
        endcase
    end
endmodule

// File: rtl/decode_ctrl.sv
// Decode stage: decodes the fetched word, detects load-use
// hazards and registers the result into the ID/EX stage.
module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit FENCE_NOP = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    decode_ctrl_if.slave    fetch,
    input  logic            flush,
    input  logic            hz_load_valid,
    input  logic [4:0]      hz_load_rd,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [31:0]     ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [2:0]      ex_imm_src,
    output ctrl_t           ex_ctrl,
    output logic            ex_illegal
);
    dec_t            w_dec;
    logic [31:0]     w_imm;
    logic [6:0]      w_opc;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic            w_stall;
    logic            w_ready;
    logic            w_accept;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;
    logic [2:0]      r_imm_src;
    ctrl_t           r_ctrl;
    logic            r_illegal;

    assign w_dec = decode(fetch.if_instr, FENCE_NOP);
    assign w_opc = fetch.if_instr[6:0];
    assign w_rs1 = fetch.if_instr[19:15];
    assign w_rs2 = fetch.if_instr[24:20];

    decode_ctrl_imm_extend u_imm (
        .i_instr   (fetch.if_instr[31:7]),
        .i_imm_src (w_dec.imm_src),
        .o_imm     (w_imm)
    );

    assign w_uses_rs1 = (w_opc != OPC_LUI)
                      & (w_opc != OPC_AUIPC)
                      & (w_opc != OPC_JAL);
    assign w_uses_rs2 = (w_opc == OPC_OP)
                      | (w_opc == OPC_STORE)
                      | (w_opc == OPC_BRANCH);

    assign w_stall = hz_load_valid
                   & (hz_load_rd != 5'd0)
                   & ((w_uses_rs1 & (w_rs1 == hz_load_rd))
                   |  (w_uses_rs2 & (w_rs2 == hz_load_rd)));

    // Flush does not gate ready: fetch still sees its word
    // consumed, the word is simply dropped below.
    assign w_ready  = (!r_valid | ex_ready) & !w_stall;
    assign w_accept = fetch.if_valid & w_ready;
    assign fetch.id_ready = w_ready;

    // ID/EX register: flush kills, accept loads, a drained
    // slot becomes a bubble, otherwise hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_funct3  <= '0;
            r_imm_src <= '0;
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_pc      <= fetch.if_pc;
            r_imm     <= w_imm;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= fetch.if_instr[11:7];
            r_funct3  <= fetch.if_instr[14:12];
            r_imm_src <= w_dec.imm_src;
            r_ctrl    <= w_dec.ctrl;
            r_illegal <= w_dec.illegal;
        end else if (ex_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign ex_valid   = r_valid;
    assign ex_pc      = r_pc;
    assign ex_imm     = r_imm;
    assign ex_rs1     = r_rs1;
    assign ex_rs2     = r_rs2;
    assign ex_rd      = r_rd;
    assign ex_funct3  = r_funct3;
    assign ex_imm_src = r_imm_src;
    assign ex_ctrl    = r_ctrl;
    assign ex_illegal = r_illegal;
endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: decode table, handshake corner
// sequences and randomized traffic against a reference model.
module tb_decode_ctrl;
    import decode_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        hz_load_valid;
    logic [4:0]  hz_load_rd;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic [2:0]  ex_imm_src;
    ctrl_t       ex_ctrl;
    logic        ex_illegal;

    decode_ctrl_if #(.XLEN(32)) fif ();

    decode_ctrl #(.XLEN(32), .FENCE_NOP(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch         (fif),
        .flush         (flush),
        .hz_load_valid (hz_load_valid),
        .hz_load_rd    (hz_load_rd),
        .ex_ready      (ex_ready),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_funct3     (ex_funct3),
        .ex_imm_src    (ex_imm_src),
        .ex_ctrl       (ex_ctrl),
        .ex_illegal    (ex_illegal)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  isrc;
        logic [7:0]  ctrl;
        logic        ill;
    } md_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] imm;
        logic [2:0]  isrc;
        logic [7:0]  ctrl;
        logic        ill;
    } vec_t;

    // reference ID/EX contents
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_ins;
    md_t         m_d;
    logic        s_rdy;

    task automatic chk(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h",
                     nm, act, exp);
        end
    endtask

    function automatic md_t m_dec(input logic [31:0] w);
        md_t r;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic wr, mr, mw, br, jp, as, md, sb;
        opc = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        {wr, mr, mw, br, jp, as, md, sb} = 8'd0;
        r.ill = 1'b0;
        r.isrc = 3'd0;
        if (opc == 7'h37 || opc == 7'h17) begin
            r.isrc = 3'd3; wr = 1;
        end else if (opc == 7'h6F) begin
            r.isrc = 3'd4; wr = 1; jp = 1;
        end else if (opc == 7'h67) begin
            wr = 1; jp = 1; r.ill = (f3 != 0);
        end else if (opc == 7'h63) begin
            r.isrc = 3'd2; br = 1;
            r.ill = (f3 inside {3'd2, 3'd3});
        end else if (opc == 7'h03) begin
            wr = 1; mr = 1;
            r.ill = !(f3 inside {3'd0, 3'd1, 3'd2,
                                 3'd4, 3'd5});
        end else if (opc == 7'h23) begin
            r.isrc = 3'd1; mw = 1;
            r.ill = !(f3 inside {3'd0, 3'd1, 3'd2});
        end else if (opc == 7'h13) begin
            wr = 1; as = 1;
            sb = (f3 == 5) && (f7 == 7'd32);
            r.ill = (f3 == 1 && f7 != 0)
                 || (f3 == 5 && !(f7 inside {7'd0, 7'd32}));
        end else if (opc == 7'h33) begin
            wr = 1;
            md = (f7 == 7'd1);
            sb = (f7 == 7'd32);
            r.ill = !(f7 == 0 || f7 == 1 ||
                      (f7 == 32 && f3 inside {3'd0, 3'd5}));
        end else if (opc == 7'h0F) begin
            r.ill = 1'b0;
        end else begin
            r.ill = 1'b1;
        end
        wr = wr && (w[11:7] != 0);
        r.ctrl = {wr, mr, mw, br, jp, as, md, sb};
        if (r.ill) begin
            r.ctrl = 8'd0;
            r.isrc = 3'd0;
        end
        case (r.isrc)
            3'd1: r.imm = (32'($signed(w) >>> 20) & ~32'h1F)
                        | 32'(w[11:7]);
            3'd2: r.imm = (w[31] ? -32'd4096 : 32'd0)
                        + 32'(w[7]) * 2048
                        + 32'(w[30:25]) * 32
                        + 32'(w[11:8]) * 2;
            3'd3: r.imm = w & 32'hFFFFF000;
            3'd4: r.imm = (w[31] ? -32'd1048576 : 32'd0)
                        + 32'(w[19:12]) * 4096
                        + 32'(w[20]) * 2048
                        + 32'(w[30:21]) * 2;
            default: r.imm = 32'($signed(w) >>> 20);
        endcase
        return r;
    endfunction

    function automatic logic m_stall(input logic [31:0] w,
                                     input logic hv,
                                     input logic [4:0] hrd);
        logic u1, u2;
        u1 = !(w[6:0] inside {7'h37, 7'h17, 7'h6F});
        u2 = (w[6:0] inside {7'h33, 7'h23, 7'h63});
        return hv && hrd != 0 &&
               ((u1 && w[19:15] == hrd) ||
                (u2 && w[24:20] == hrd));
    endfunction

    task automatic chk_out(input string nm);
        chk({nm, ".valid"}, 128'(ex_valid), 128'(m_valid));
        if (m_valid)
            chk({nm, ".bundle"},
                {ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
                 ex_funct3, ex_imm_src, ex_ctrl, ex_illegal},
                {m_pc, m_d.imm, m_ins[19:15], m_ins[24:20],
                 m_ins[11:7], m_ins[14:12], m_d.isrc,
                 m_d.ctrl, m_d.ill});
    endtask

    task automatic step(input logic iv,
                        input logic [31:0] ins,
                        input logic [31:0] pc,
                        input logic exr,
                        input logic hv,
                        input logic [4:0] hrd,
                        input logic fl,
                        input string nm);
        logic rdy;
        @(negedge clk);
        fif.if_valid  = iv;
        fif.if_instr  = ins;
        fif.if_pc     = pc;
        ex_ready      = exr;
        hz_load_valid = hv;
        hz_load_rd    = hrd;
        flush         = fl;
        #1;
        rdy = (!m_valid || exr) && !m_stall(ins, hv, hrd);
        s_rdy = fif.id_ready;
        chk({nm, ".id_ready"}, 128'(s_rdy), 128'(rdy));
        if (fl) begin
            m_valid = 1'b0;
        end else if (iv && rdy) begin
            m_valid = 1'b1;
            m_pc = pc;
            m_ins = ins;
            m_d = m_dec(ins);
        end else if (exr) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk_out(nm);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        logic [6:0] opcs [10];
        logic [6:0] f7s [3];
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
        f7s = '{7'd0, 7'd32, 7'd1};
        w = $urandom;
        if ($urandom_range(0, 7) != 0) begin
            w[6:0] = opcs[$urandom_range(0, 9)];
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0)
                w[31:25] = f7s[$urandom_range(0, 2)];
        end
        return w;
    endfunction

    vec_t tbl [18];

    initial begin
        tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd0, 8'h84, 1'b0};
        tbl[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd2, 8'h10, 1'b0};
        tbl[2]  = '{32'h00000000, 32'h00000000, 3'd0, 8'h00, 1'b1};
        tbl[3]  = '{32'h00728333, 32'h00000007, 3'd0, 8'h80, 1'b0};
        tbl[4]  = '{32'h403100B3, 32'h00000403, 3'd0, 8'h81, 1'b0};
        tbl[5]  = '{32'h023100B3, 32'h00000023, 3'd0, 8'h82, 1'b0};
        tbl[6]  = '{32'h00512423, 32'h00000008, 3'd1, 8'h20, 1'b0};
        tbl[7]  = '{32'hFF80A183, 32'hFFFFFFF8, 3'd0, 8'hC0, 1'b0};
        tbl[8]  = '{32'h123452B7, 32'h12345000, 3'd3, 8'h80, 1'b0};
        tbl[9]  = '{32'hFF9FF06F, 32'hFFFFFFF8, 3'd4, 8'h08, 1'b0};
        tbl[10] = '{32'h00008067, 32'h00000000, 3'd0, 8'h08, 1'b0};
        tbl[11] = '{32'h00009067, 32'h00000000, 3'd0, 8'h00, 1'b1};
        tbl[12] = '{32'h40315093, 32'h00000403, 3'd0, 8'h85, 1'b0};
        tbl[13] = '{32'h40311093, 32'h00000403, 3'd0, 8'h00, 1'b1};
        tbl[14] = '{32'h0FF0000F, 32'h000000FF, 3'd0, 8'h00, 1'b0};
        tbl[15] = '{32'h00000073, 32'h00000000, 3'd0, 8'h00, 1'b1};
        tbl[16] = '{32'hFE002EE3, 32'hFFFFFFE0, 3'd0, 8'h00, 1'b1};
        tbl[17] = '{32'h00001017, 32'h00001000, 3'd3, 8'h00, 1'b0};

        rst_n = 1'b0;
        fif.if_valid = 1'b0;
        fif.if_instr = '0;
        fif.if_pc = '0;
        ex_ready = 1'b0;
        hz_load_valid = 1'b0;
        hz_load_rd = '0;
        flush = 1'b0;
        m_valid = 1'b0;
        m_pc = '0;
        m_ins = '0;
        m_d = '{32'd0, 3'd0, 8'd0, 1'b0};
        s_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset",
            {ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_funct3, ex_imm_src, ex_ctrl, ex_illegal},
            128'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(1, tbl[i].ins, 32'h1000 + 32'(i * 4),
                 1, 0, 0, 0, "tbl");
            chk($sformatf("tbl[%0d]", i),
                {ex_valid, ex_imm, ex_imm_src, ex_ctrl,
                 ex_illegal, ex_rd, ex_funct3},
                {1'b1, tbl[i].imm, tbl[i].isrc, tbl[i].ctrl,
                 tbl[i].ill, tbl[i].ins[11:7],
                 tbl[i].ins[14:12]});
        end

        // backpressure: hold three cycles, then drain in order
        step(1, 32'hFFF00093, 32'h100, 1, 0, 0, 0, "bp_a");
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h00728333, 32'h104, 0, 0, 0, 0, "bp_h");
            chk("bp_hold_rdy", 128'(s_rdy), 128'd0);
            chk("bp_hold_pc", {ex_valid, ex_pc},
                {1'b1, 32'h100});
        end
        step(1, 32'h00728333, 32'h104, 1, 0, 0, 0, "bp_b");
        chk("bp_b_pc", {ex_valid, ex_pc}, {1'b1, 32'h104});
        step(1, 32'h00512423, 32'h108, 1, 0, 0, 0, "bp_c");
        chk("bp_c_pc", {ex_valid, ex_pc}, {1'b1, 32'h108});
        step(0, 32'h0, 32'h10C, 1, 0, 0, 0, "bp_end");
        chk("bp_bubble", 128'(ex_valid), 128'd0);

        // load-use on rs1 = x5
        for (int i = 0; i < 2; i++) begin
            step(1, 32'h00728333, 32'h200, 1, 1, 5, 0, "lu");
            chk("lu_rdy", 128'(s_rdy), 128'd0);
            chk("lu_bubble", 128'(ex_valid), 128'd0);
        end
        step(1, 32'h00728333, 32'h200, 1, 1, 0, 0, "lu_rd0");
        chk("lu_rd0_v", 128'(ex_valid), 128'd1);
        step(1, 32'h123452B7, 32'h204, 1, 1, 5, 0, "lu_lui");
        chk("lu_lui_v", 128'(ex_valid), 128'd1);

        // flush with a same-cycle accept
        step(1, 32'hFFF00093, 32'h300, 1, 0, 0, 1, "fl");
        chk("fl_rdy", 128'(s_rdy), 128'd1);
        chk("fl_valid", 128'(ex_valid), 128'd0);

        // asynchronous reset mid-stream
        step(1, 32'hFFF00093, 32'h400, 1, 0, 0, 0, "ar");
        #2 rst_n = 1'b0;
        #1;
        chk("ar_async",
            {ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_funct3, ex_imm_src, ex_ctrl, ex_illegal},
            128'd0);
        m_valid = 1'b0;
        fif.if_valid = 1'b0;
        flush = 1'b0;
        hz_load_valid = 1'b0;
        ex_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 32'hFE000EE3, 32'h500, 1, 0, 0, 0, "ar_post");
        chk("ar_post_v",
            {ex_valid, ex_pc, ex_imm, ex_imm_src, ex_ctrl},
            {1'b1, 32'h500, 32'hFFFFFFFC, 3'd2, 8'h10});

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, rnd_instr(),
                 $urandom & 32'hFFFFFFFC,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0,
                 5'($urandom_range(0, 7)),
                 $urandom_range(0, 15) == 0, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end
endmodule
